// File: rtl/pe_result_drain.sv
// Result drain for the PE array: buffers whole result beats in a small FIFO and
// serializes each beat one chain word per cycle onto a valid/ready stream.
module pe_result_drain #(
    parameter int unsigned NUM_CHAINS            = 8,
    parameter int unsigned NUM_RESULTS_PER_CYCLE = 2,
    parameter int unsigned RESULT_WIDTH          = 32,
    parameter int unsigned FIFO_DEPTH            = 16,
    parameter int unsigned ALMOST_FULL_MARGIN    = 4,
    localparam int unsigned WORD_W = NUM_RESULTS_PER_CYCLE * RESULT_WIDTH,
    localparam int unsigned BEAT_W = NUM_CHAINS * WORD_W,
    localparam int unsigned CTR_W  = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1,
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [BEAT_W-1:0] i_result,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WORD_W-1:0] o_data,
    output logic [CTR_W-1:0]  o_chain_idx,
    output logic              o_last,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_almost_full,
    output logic              o_overflow
);

    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_THRESH_C = CNT_W'(FIFO_DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [CTR_W-1:0] LAST_CTR_C  = CTR_W'(NUM_CHAINS - 1);

    typedef enum logic [0:0] {StEmpty, StDrain} state_e;

    state_e            r_state;
    logic [BEAT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CTR_W-1:0]  r_ctr;
    logic              r_almost_full;
    logic              r_overflow;

    logic              w_xfer;
    logic              w_last_word;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_count_next;
    logic [BEAT_W-1:0] w_head;
    logic [WORD_W-1:0] w_word;

    assign w_xfer      = o_valid && i_ready;
    assign w_last_word = (r_ctr == LAST_CTR_C);
    assign w_pop       = w_xfer && w_last_word;
    // A full FIFO still accepts a beat on the same edge its head word leaves.
    assign w_push      = i_valid && ((r_count != DEPTH_C) || w_pop);
    assign w_drop      = i_valid && (r_count == DEPTH_C) && !w_pop;
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_word = '0;
        for (int c = 0; c < int'(NUM_CHAINS); c++) begin
            if (r_ctr == CTR_W'(c)) begin
                w_word = w_head[c*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StEmpty;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_ctr         <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_result;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_xfer) begin
                r_ctr <= w_last_word ? '0 : r_ctr + CTR_W'(1);
            end
            r_count       <= w_count_next;
            r_almost_full <= (w_count_next >= AF_THRESH_C);
            r_overflow    <= r_overflow | w_drop;

            unique case (r_state)
                StEmpty: if (w_push) r_state <= StDrain;
                StDrain: if (w_pop && !w_push && r_count == CNT_W'(1)) r_state <= StEmpty;
                default: r_state <= StEmpty;
            endcase
        end
    end

    assign o_valid       = (r_state == StDrain);
    assign o_data        = w_word;
    assign o_chain_idx   = r_ctr;
    assign o_last        = o_valid && w_last_word;
    assign o_count       = r_count;
    assign o_almost_full = r_almost_full;
    assign o_overflow    = r_overflow;

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Downstream stage of the PE array. Captures each valid result beat (all chains × results-per-cycle) into a beat FIFO and emits it one chain-word per cycle on a valid/ready stream, with chain index and end-of-beat marker. The PE array cannot be stalled, so this block absorbs backpressure, reports occupancy and flags overflow stickily.

## Interface

- NUM_CHAINS, 8, chains per input beat (≥1)
- NUM_RESULTS_PER_CYCLE, 2, results per chain per beat
- RESULT_WIDTH, 32, bits per result
- FIFO_DEPTH, 16, beat entries; power of two, ≥2
- ALMOST_FULL_MARGIN, 4, o_almost_full asserts when count ≥ FIFO_DEPTH − margin (1 ≤ margin < FIFO_DEPTH)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- i_valid  in  1  result beat present (PE array ovalid)
- i_result  in  NUM_CHAINS·NUM_RESULTS_PER_CYCLE·RESULT_WIDTH  beat; chain c occupies word c (lowest chain in LSBs), result r within chain at bits [r·RESULT_WIDTH +: RESULT_WIDTH]
- o_valid  out  1  output word valid
- i_ready  in  1  consumer accepts
- o_data  out  NUM_RESULTS_PER_CYCLE·RESULT_WIDTH  chain word of head beat
- o_chain_idx  out  $clog2(NUM_CHAINS) (min 1)  chain of o_data
- o_last  out  1  o_chain_idx == NUM_CHAINS−1 while o_valid
- o_count  out  $clog2(FIFO_DEPTH)+1  beats stored (incl. partially drained head)
- o_almost_full  out  1  occupancy threshold, registered from o_count
- o_overflow  out  1  sticky: a beat was dropped

## Operation

- Storage: FIFO_DEPTH register entries, wr_ptr/rd_ptr of $clog2(FIFO_DEPTH) bits wrapping modulo depth, count register 0..FIFO_DEPTH.
- Push: i_valid && (count < FIFO_DEPTH || pop) → write i_result at wr_ptr, wr_ptr++.
- Drop: i_valid && count == FIFO_DEPTH && !pop → beat discarded, o_overflow ← 1 until reset; pointers/count unchanged.
- Serializer chain counter ctr (0..NUM_CHAINS−1). Transfer = o_valid && i_ready. On transfer: ctr++ unless ctr == NUM_CHAINS−1, then ctr ← 0 and pop (rd_ptr++).
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- FSM: EMPTY (count==0, o_valid=0) → DRAIN when count becomes nonzero; DRAIN → EMPTY when pop with no push and count==1. ctr is 0 in EMPTY.
- o_valid = (count != 0). o_data = head entry word ctr (combinational mux from registers). o_chain_idx = ctr. o_last = o_valid && ctr == NUM_CHAINS−1.
- With NUM_CHAINS == 1 every transfer is a pop; ctr stays 0.
- o_valid, once high, holds with o_data stable until transfer (AXI-style); i_ready may toggle freely; o_valid does not depend on i_ready.
- o_almost_full ← (next count ≥ FIFO_DEPTH − ALMOST_FULL_MARGIN), registered.

## Timing

- Reset (async assert, sync-safe release): o_valid 0, o_data 0 (storage cleared), o_chain_idx 0, o_last 0, o_count 0, o_almost_full 0, o_overflow 0; FSM EMPTY. Reset mid-drain abandons partial beat; no output after release until new i_valid.
- Input-to-output latency: beat accepted at edge N into empty FIFO → o_valid high, o_chain_idx 0 during cycle N+1.
- Throughput: one chain word per cycle with i_ready held high; a beat drains in NUM_CHAINS cycles; back-to-back drain across beats has no bubble.
- Full with simultaneous push+pop: push accepted, count stays FIFO_DEPTH, no overflow.
- o_count and o_almost_full reflect state after the clock edge (one-cycle view of push/pop).

## Test plan

- Single beat, NUM_CHAINS=4, NRPC=2, RW=32, i_ready=1: chain c results {c·2, c·2+1} → 4 consecutive words, o_chain_idx 0,1,2,3, o_last only on 3, o_valid low after; first o_valid one cycle after i_valid.
- Backpressure: i_ready toggled 1,0,0,1,… during drain → o_data/o_chain_idx held across stalls; all 4 words in order, none duplicated.
- Fill, FIFO_DEPTH=4, i_ready=0, 5 beats → o_count 4, o_almost_full=1 (margin 1, from count 3), 5th beat dropped, o_overflow=1 and stays 1; draining yields beats 1–4 only.
- Full with simultaneous pop: count 4, i_ready=1 on last word of head while i_valid → o_count stays 4, o_overflow 0, new beat appears as 4th after.
- Pointer wrap: 20 beats at 1 per NUM_CHAINS cycles, i_ready=1, FIFO_DEPTH=4 → all 80 words in order, count never exceeds 1.
- Reset mid-drain at ctr=2 with 3 beats stored → outputs at reset values immediately; next beat drains from chain 0.
